// File: rtl/setn_pkg.sv
// Shared state encoding and default constants for the set-pulse generator.
package setn_pkg;

  localparam int DEF_GUARD = 2;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_GUARD = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/setn_cnt.sv
// Loadable down-counter with zero flag, shared by the SET and GUARD phases.
module setn_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/setn_pulse_gen.sv
// Active-low set-pulse sequencer: SET for LEN cycles, GUARD hold, one-cycle ACK.
module setn_pulse_gen
  import setn_pkg::*;
#(
  parameter int GUARD = DEF_GUARD,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic [LEN_W-1:0] LEN,
  input  logic             D_IN,
  output logic             SETN,
  output logic             D,
  output logic             BUSY,
  output logic             ACK
);

  localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;

  state_t           state, state_nxt;
  logic             post_rst, post_rst_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [LEN_W-1:0] len_m1;

  // Counter holds remaining cycles minus one, so LEN=0 and LEN=1 both load zero.
  assign len_m1 = (LEN == '0) ? '0 : LEN - 1'b1;

  setn_cnt #(.W(CNT_W)) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    post_rst_nxt = post_rst;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_val      = '0;
    unique case (state)
      ST_IDLE: begin
        if (REQ) begin
          state_nxt = ST_SET;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(len_m1);
        end
      end
      ST_SET: begin
        if (cnt_zero) begin
          state_nxt = ST_GUARD;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(GUARD - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_zero) begin
          // The post-reset guard returns straight to IDLE with no ACK.
          state_nxt    = post_rst ? ST_IDLE : ST_DONE;
          post_rst_nxt = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset parks the FSM in SET with a cleared counter, so release falls into GUARD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_SET;
      post_rst <= 1'b1;
      SETN     <= 1'b0;
      D        <= 1'b1;
      BUSY     <= 1'b1;
      ACK      <= 1'b0;
    end else begin
      state    <= state_nxt;
      post_rst <= post_rst_nxt;
      SETN     <= (state_nxt != ST_SET);
      BUSY     <= (state_nxt != ST_IDLE);
      ACK      <= (state_nxt == ST_DONE);
      if (state == ST_IDLE) D <= D_IN;
    end
  end

endmodule

// File: tb/tb_setn_pulse_gen.sv
// Self-checking bench: directed scenarios then random stimulus against a timeline model.
module tb_setn_pulse_gen;

  localparam int G     = 2;
  localparam int LEN_W = 4;
  localparam int INF   = 32'h7fff_ffff;

  logic             clk = 1'b0;
  logic             rst, req, d_in;
  logic [LEN_W-1:0] len;
  logic             setn, d, busy, ack;

  int n_cmp = 0;
  int n_err = 0;

  // Timeline model: edge index, current sequence window, and first edge after which IDLE holds.
  int   n         = 0;
  int   idle_from = INF;
  int   k         = 0;
  int   l_eff     = 1;
  bit   seq       = 1'b0;
  bit   rel_pend  = 1'b0;
  logic exp_setn, exp_d, exp_busy, exp_ack;
  int   ack_seen  = 0;

  setn_pulse_gen #(.GUARD(G), .LEN_W(LEN_W)) dut (
    .CLK  (clk),
    .RST  (rst),
    .REQ  (req),
    .LEN  (len),
    .D_IN (d_in),
    .SETN (setn),
    .D    (d),
    .BUSY (busy),
    .ACK  (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h, want %0h", tag, n, act, exp_v);
    end
  endtask

  task automatic model_edge(input logic r, input logic q, input logic [LEN_W-1:0] ln, input logic di);
    bit pre_idle;
    n++;
    pre_idle = (n > idle_from);
    if (r) begin
      rel_pend  = 1'b1;
      seq       = 1'b0;
      idle_from = INF;
      exp_d     = 1'b1;
      exp_setn  = 1'b0;
      exp_busy  = 1'b1;
      exp_ack   = 1'b0;
    end else begin
      if (pre_idle) exp_d = di;
      if (rel_pend) begin
        rel_pend  = 1'b0;
        idle_from = n + G;
      end else if (pre_idle && q) begin
        seq       = 1'b1;
        k         = n;
        l_eff     = (ln == 0) ? 1 : int'(ln);
        idle_from = k + l_eff + G + 1;
      end
      exp_setn = !(seq && n >= k && n <= k + l_eff - 1);
      exp_busy = (n < idle_from);
      exp_ack  = seq && (n == k + l_eff + G);
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare on the falling edge.
  task automatic step(input logic r, input logic q, input logic [LEN_W-1:0] ln, input logic di);
    rst  = r;
    req  = q;
    len  = ln;
    d_in = di;
    @(posedge clk);
    model_edge(r, q, ln, di);
    @(negedge clk);
    check("setn", 32'(setn), 32'(exp_setn));
    check("busy", 32'(busy), 32'(exp_busy));
    check("ack",  32'(ack),  32'(exp_ack));
    check("d",    32'(d),    32'(exp_d));
    if (ack) ack_seen++;
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; len = '0; d_in = 1'b0;
    @(negedge clk);

    // Reset held three cycles, then release and post-reset guard.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    idle_cycles(4);

    // Basic LEN=3 request pulse.
    step(1'b0, 1'b1, 4'd3, 1'b1);
    idle_cycles(8);

    // Boundary lengths 0 and 15.
    step(1'b0, 1'b1, 4'd0, 1'b0);
    idle_cycles(5);
    step(1'b0, 1'b1, 4'd15, 1'b1);
    idle_cycles(20);

    // Second request during SET is ignored; exactly one ACK expected.
    ack_seen = 0;
    step(1'b0, 1'b1, 4'd2, 1'b1);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    step(1'b0, 1'b0, 4'd7, 1'b1);
    idle_cycles(10);
    check("single_ack", 32'(ack_seen), 32'd1);

    // Reset asserted while in GUARD abandons the sequence.
    ack_seen = 0;
    step(1'b0, 1'b1, 4'd2, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    idle_cycles(6);
    check("no_ack_after_rst", 32'(ack_seen), 32'd0);

    // Data path: D_IN toggling while BUSY, then D_IN=0 in IDLE.
    step(1'b0, 1'b1, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 1'(i));
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Held REQ restarts immediately after DONE.
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 4'd1, 1'b0);
    idle_cycles(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 2) == 0),
           LEN_W'($urandom_range(0, 15)),
           1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
